// File: rtl/alu_cmp_sequencer.sv
// Handshaked front-end for the 16-bit ALU comparator: issues one compare and decodes the returned code.
// Optional statistics counters are built only when CMP_STATS_EN is defined.
module alu_cmp_sequencer #(
    parameter int IN_WIDTH      = 16,
    parameter int CMP_OUT_WIDTH = 16,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [IN_WIDTH-1:0]      REQ_A,
    input  logic [IN_WIDTH-1:0]      REQ_B,
    input  logic [1:0]               REQ_FUN,
    output logic [IN_WIDTH-1:0]      CMP_A,
    output logic [IN_WIDTH-1:0]      CMP_B,
    output logic [1:0]               CMP_FUN,
    output logic                     CMP_EN,
    input  logic [CMP_OUT_WIDTH-1:0] CMP_OUT,
    input  logic                     CMP_Flag,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic                     RSP_TRUE,
    output logic [1:0]               RSP_FUN,
    output logic                     RSP_ERR,
    output logic [CNT_WIDTH-1:0]     EQ_CNT,
    output logic [CNT_WIDTH-1:0]     GT_CNT,
    output logic [CNT_WIDTH-1:0]     LT_CNT,
    output logic [CNT_WIDTH-1:0]     ERR_CNT
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t r_state;
    state_t w_next;

    logic [IN_WIDTH-1:0]      r_cmp_a;
    logic [IN_WIDTH-1:0]      r_cmp_b;
    logic [1:0]               r_cmp_fun;
    logic                     r_cmp_en;
    logic                     r_rsp_valid;
    logic                     r_rsp_true;
    logic [1:0]               r_rsp_fun;
    logic                     r_rsp_err;

    logic                     w_req_ready;
    logic                     w_accept;
    logic                     w_rsp_done;
    logic [CMP_OUT_WIDTH-1:0] w_expect;
    logic                     w_dec_true;
    logic                     w_dec_err;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (REQ_VALID) w_next = ISSUE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = RESP;
            RESP:    if (RSP_READY) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_req_ready  = (r_state == IDLE);
        w_accept     = w_req_ready && REQ_VALID;
        w_rsp_done   = (r_state == RESP) && RSP_READY;
        w_expect     = '0;
        w_expect[1:0] = r_cmp_fun;
        w_dec_true   = 1'b0;
        w_dec_err    = 1'b0;
        // Flag check comes first: a missing flag makes any code untrustworthy.
        if (!CMP_Flag)
            w_dec_err = 1'b1;
        else if (CMP_OUT == '0)
            w_dec_true = 1'b0;
        else if (CMP_OUT == w_expect && r_cmp_fun != 2'd0)
            w_dec_true = 1'b1;
        else
            w_dec_err = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cmp_a     <= '0;
            r_cmp_b     <= '0;
            r_cmp_fun   <= '0;
            r_cmp_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_true  <= 1'b0;
            r_rsp_fun   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cmp_en <= w_accept;
            if (w_accept) begin
                r_cmp_a   <= REQ_A;
                r_cmp_b   <= REQ_B;
                r_cmp_fun <= REQ_FUN;
                r_rsp_fun <= REQ_FUN;
            end
            if (r_state == CAPTURE) begin
                r_rsp_valid <= 1'b1;
                r_rsp_true  <= w_dec_true;
                r_rsp_err   <= w_dec_err;
            end else if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef CMP_STATS_EN
    logic [CNT_WIDTH-1:0] r_eq_cnt;
    logic [CNT_WIDTH-1:0] r_gt_cnt;
    logic [CNT_WIDTH-1:0] r_lt_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;

    // Saturating counters, updated on the same edge the response is decoded.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_eq_cnt  <= '0;
            r_gt_cnt  <= '0;
            r_lt_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (r_state == CAPTURE) begin
            if (w_dec_true) begin
                case (r_cmp_fun)
                    2'd1: if (r_eq_cnt != '1) r_eq_cnt <= r_eq_cnt + 1'b1;
                    2'd2: if (r_gt_cnt != '1) r_gt_cnt <= r_gt_cnt + 1'b1;
                    2'd3: if (r_lt_cnt != '1) r_lt_cnt <= r_lt_cnt + 1'b1;
                    default: ;
                endcase
            end
            if (w_dec_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign EQ_CNT  = r_eq_cnt;
    assign GT_CNT  = r_gt_cnt;
    assign LT_CNT  = r_lt_cnt;
    assign ERR_CNT = r_err_cnt;
`else
    assign EQ_CNT  = '0;
    assign GT_CNT  = '0;
    assign LT_CNT  = '0;
    assign ERR_CNT = '0;
`endif

    assign REQ_READY = w_req_ready;
    assign CMP_A     = r_cmp_a;
    assign CMP_B     = r_cmp_b;
    assign CMP_FUN   = r_cmp_fun;
    assign CMP_EN    = r_cmp_en;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_TRUE  = r_rsp_true;
    assign RSP_FUN   = r_rsp_fun;
    assign RSP_ERR   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmp_sequencer.sv
// Bench for alu_cmp_sequencer: comparator stub, vector table, random traffic and corner sequences.
// Counter expectations follow CMP_STATS_EN when defined, otherwise counters must read 0.
module tb_alu_cmp_sequencer;

    localparam int W  = 16;
    localparam int CW = 16;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [W-1:0]  REQ_A, REQ_B;
    logic [1:0]    REQ_FUN;
    logic [W-1:0]  CMP_A, CMP_B;
    logic [1:0]    CMP_FUN;
    logic          CMP_EN;
    logic [CW-1:0] CMP_OUT  = '0;
    logic          CMP_Flag = 1'b0;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic          RSP_TRUE;
    logic [1:0]    RSP_FUN;
    logic          RSP_ERR;
    logic [NW-1:0] EQ_CNT, GT_CNT, LT_CNT, ERR_CNT;

    alu_cmp_sequencer #(.IN_WIDTH(W), .CMP_OUT_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUN(REQ_FUN),
        .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_FUN(CMP_FUN), .CMP_EN(CMP_EN),
        .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_TRUE(RSP_TRUE), .RSP_FUN(RSP_FUN), .RSP_ERR(RSP_ERR),
        .EQ_CNT(EQ_CNT), .GT_CNT(GT_CNT), .LT_CNT(LT_CNT), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int m_eq = 0, m_gt = 0, m_lt = 0, m_err = 0;

    // Comparator stub: registers a code on the edge where CMP_EN is high, or an injected code.
    logic          inj_use  = 1'b0;
    logic [CW-1:0] inj_code = '0;
    logic          inj_flag = 1'b1;

    function automatic logic [CW-1:0] ref_code(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [1:0] f);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            2'd1:    return (sa == sb) ? 16'd1 : 16'd0;
            2'd2:    return (sa >  sb) ? 16'd2 : 16'd0;
            2'd3:    return (sa <  sb) ? 16'd3 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (CMP_EN) begin
            CMP_OUT  <= inj_use ? inj_code : ref_code(CMP_A, CMP_B, CMP_FUN);
            CMP_Flag <= inj_use ? inj_flag : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_rsp(input logic [CW-1:0] code, input logic flag, input logic [1:0] f,
                                      output logic t, output logic e);
        t = 1'b0;
        e = 1'b0;
        if (!flag)                          e = 1'b1;
        else if (code == 0)                 t = 1'b0;
        else if (code == CW'(f) && f != 0)  t = 1'b1;
        else                                e = 1'b1;
    endfunction

    function automatic void model_count(input logic [1:0] f, input logic t, input logic e);
        if (t && f == 2'd1 && m_eq  < SAT) m_eq++;
        if (t && f == 2'd2 && m_gt  < SAT) m_gt++;
        if (t && f == 2'd3 && m_lt  < SAT) m_lt++;
        if (e && m_err < SAT)              m_err++;
    endfunction

    task automatic chk_counters();
`ifdef CMP_STATS_EN
        chk("eq_cnt",  EQ_CNT,  m_eq);
        chk("gt_cnt",  GT_CNT,  m_gt);
        chk("lt_cnt",  LT_CNT,  m_lt);
        chk("err_cnt", ERR_CNT, m_err);
`else
        chk("eq_cnt_off",  EQ_CNT,  0);
        chk("gt_cnt_off",  GT_CNT,  0);
        chk("lt_cnt_off",  LT_CNT,  0);
        chk("err_cnt_off", ERR_CNT, 0);
`endif
    endtask

    // Entered and left at posedge+1; with READY already high the accept lands on the next edge.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] f,
                           input logic use_inj, input logic [CW-1:0] code, input logic flag,
                           input logic exp_t, input logic exp_e);
        int waitc = 0;
        while (!REQ_READY && waitc < 20) begin
            @(posedge CLK); #1;
            waitc++;
        end
        if (!REQ_READY) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        inj_use = use_inj; inj_code = code; inj_flag = flag;
        REQ_VALID = 1'b1; REQ_A = a; REQ_B = b; REQ_FUN = f;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("issue_en",    CMP_EN, 1);
        chk("issue_a",     CMP_A, a);
        chk("issue_b",     CMP_B, b);
        chk("issue_fun",   CMP_FUN, f);
        chk("issue_ready", REQ_READY, 0);
        @(posedge CLK); #1;
        chk("cap_en",    CMP_EN, 0);
        chk("cap_valid", RSP_VALID, 0);
        @(posedge CLK); #1;
        chk("rsp_valid", RSP_VALID, 1);
        chk("rsp_true",  RSP_TRUE, exp_t);
        chk("rsp_err",   RSP_ERR, exp_e);
        chk("rsp_fun",   RSP_FUN, f);
        model_count(f, exp_t, exp_e);
        chk_counters();
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        chk("done_valid", RSP_VALID, 0);
        chk("done_ready", REQ_READY, 1);
        chk("done_true_kept", RSP_TRUE, exp_t);
        chk("done_err_kept",  RSP_ERR, exp_e);
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [1:0]    f;
        logic          use_inj;
        logic [CW-1:0] code;
        logic          flag;
        logic          exp_t;
        logic          exp_e;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic t, e;
        logic [W-1:0] ra, rb;
        logic [1:0] rf;
        logic ruse, rflag;
        logic [CW-1:0] rcode;

        tbl[0]  = '{16'd5,      16'd5,      2'd1, 1'b0, 16'd0,      1'b1, 1'b1, 1'b0};
        tbl[1]  = '{16'hFFFD,   16'd7,      2'd2, 1'b0, 16'd0,      1'b1, 1'b0, 1'b0};
        tbl[2]  = '{16'hFFFD,   16'd7,      2'd3, 1'b0, 16'd0,      1'b1, 1'b1, 1'b0};
        tbl[3]  = '{16'd5,      16'd5,      2'd1, 1'b1, 16'd2,      1'b1, 1'b0, 1'b1};
        tbl[4]  = '{16'd9,      16'd9,      2'd1, 1'b1, 16'd1,      1'b0, 1'b0, 1'b1};
        tbl[5]  = '{16'd0,      16'd0,      2'd0, 1'b0, 16'd0,      1'b1, 1'b0, 1'b0};
        tbl[6]  = '{16'd1,      16'd2,      2'd2, 1'b1, 16'h0102,   1'b1, 1'b0, 1'b1};
        tbl[7]  = '{16'h8000,   16'h7FFF,   2'd3, 1'b0, 16'd0,      1'b1, 1'b1, 1'b0};
        tbl[8]  = '{16'h7FFF,   16'h8000,   2'd2, 1'b0, 16'd0,      1'b1, 1'b1, 1'b0};
        tbl[9]  = '{16'd4,      16'd4,      2'd0, 1'b1, 16'd1,      1'b1, 1'b0, 1'b1};
        tbl[10] = '{16'd3,      16'd4,      2'd1, 1'b0, 16'd0,      1'b1, 1'b0, 1'b0};

        RST = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        REQ_A = '0; REQ_B = '0; REQ_FUN = '0;
        #1;
        chk("rst_en",    CMP_EN, 0);
        chk("rst_valid", RSP_VALID, 0);
        chk("rst_a",     CMP_A, 0);
        chk("rst_fun",   CMP_FUN, 0);
        chk("rst_true",  RSP_TRUE, 0);
        chk_counters();
        #21 RST = 1'b1;
        @(posedge CLK); #1;
        chk("post_rst_ready", REQ_READY, 1);

        for (int i = 0; i < 11; i++)
            run_txn(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].use_inj, tbl[i].code, tbl[i].flag,
                    tbl[i].exp_t, tbl[i].exp_e);

        // Backpressure: response held 10 cycles while a second request waits.
        inj_use = 1'b0;
        REQ_VALID = 1'b1; REQ_A = 16'd10; REQ_B = 16'd3; REQ_FUN = 2'd2;
        @(posedge CLK); #1;
        REQ_A = 16'd77; REQ_B = 16'd77; REQ_FUN = 2'd1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("bp_valid", RSP_VALID, 1);
        chk("bp_true",  RSP_TRUE, 1);
        model_count(2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            chk("bp_ready_low", REQ_READY, 0);
            chk("bp_en_low",    CMP_EN, 0);
            chk("bp_hold_valid", RSP_VALID, 1);
            chk("bp_hold_true", RSP_TRUE, 1);
            chk("bp_hold_fun",  RSP_FUN, 2);
            chk("bp_hold_err",  RSP_ERR, 0);
            chk("bp_hold_a",    CMP_A, 10);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        chk("bp_release_valid", RSP_VALID, 0);
        chk("bp_release_ready", REQ_READY, 1);
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("bp_next_en", CMP_EN, 1);
        chk("bp_next_a",  CMP_A, 77);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("bp_next_valid", RSP_VALID, 1);
        chk("bp_next_true",  RSP_TRUE, 1);
        chk("bp_next_fun",   RSP_FUN, 1);
        model_count(2'd1, 1'b1, 1'b0);
        chk_counters();
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;

        // Reset asserted while the request is in ISSUE.
        REQ_VALID = 1'b1; REQ_A = 16'd1234; REQ_B = 16'd1; REQ_FUN = 2'd2;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        chk("mid_issue_en", CMP_EN, 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_en",    CMP_EN, 0);
        chk("mid_rst_a",     CMP_A, 0);
        chk("mid_rst_b",     CMP_B, 0);
        chk("mid_rst_fun",   CMP_FUN, 0);
        chk("mid_rst_valid", RSP_VALID, 0);
        chk("mid_rst_true",  RSP_TRUE, 0);
        chk("mid_rst_rfun",  RSP_FUN, 0);
        chk("mid_rst_err",   RSP_ERR, 0);
        m_eq = 0; m_gt = 0; m_lt = 0; m_err = 0;
        chk_counters();
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("in_rst_valid", RSP_VALID, 0);
        end
        #2 RST = 1'b1;
        @(posedge CLK); #1;
        chk("after_rst_ready", REQ_READY, 1);
        chk("after_rst_valid", RSP_VALID, 0);
        run_txn(16'd8, 16'd2, 2'd2, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);

        // Random traffic against the reference model, with occasional corrupted codes.
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom_range(0, 65535));
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom_range(0, 65535));
            rf = 2'($urandom_range(0, 3));
            ruse  = ($urandom_range(0, 4) == 0);
            rcode = ($urandom_range(0, 1) == 0) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, 65535));
            rflag = ($urandom_range(0, 2) != 0);
            if (ruse) model_rsp(rcode, rflag, rf, t, e);
            else      model_rsp(ref_code(ra, rb, rf), 1'b1, rf, t, e);
            run_txn(ra, rb, rf, ruse, rcode, rflag, t, e);
        end

        // Enough true EQ compares to drive a 4-bit counter into saturation.
        for (int i = 0; i < SAT + 3; i++)
            run_txn(16'd42, 16'd42, 2'd1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
`ifdef CMP_STATS_EN
        chk("eq_saturated", EQ_CNT, SAT);
`else
        chk("eq_absent", EQ_CNT, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
